alu_src_b_stage: RTL and testbench

Parametrised successor to the multicycle datapath's ALU-B operand mux. Selects and forms the ALU B operand from one of these sources:
- register B
- a constant increment
- the extended immediate
- the extended immediate shifted left by 2

The result is registered and delivered over a valid/ready handshake with a 2-entry skid buffer, so the ALU-side stall never combinationally reaches the control unit.

---
 rtl/alu_src_b_pkg.sv | 19 +
 rtl/alu_src_b_form.sv | 42 ++++
 rtl/alu_src_b_stage.sv | 123 ++++++++++++
 tb/tb_alu_src_b_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_src_b_pkg.sv
// Shared select codes and FIFO state encoding for the ALU B-operand stage.
// Optional sel=4 (lui) operand is enabled by ALU_SRC_B_LUI_EN.
package alu_src_b_pkg;

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SRC_B_REG     = 3'd0;
    localparam logic [SEL_W-1:0] SRC_B_INC     = 3'd1;
    localparam logic [SEL_W-1:0] SRC_B_IMM     = 3'd2;
    localparam logic [SEL_W-1:0] SRC_B_IMM_SH2 = 3'd3;
    localparam logic [SEL_W-1:0] SRC_B_LUI     = 3'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/alu_src_b_form.sv
// Combinational ALU B-operand former: picks reg_b, increment, or extended immediate.
// sel=4 (lui placement) is legal only when ALU_SRC_B_LUI_EN is defined.
module alu_src_b_form
    import alu_src_b_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned CONST_INC = 4
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [IMM_W-1:0] imm,
    input  logic             imm_sign,
    output logic [WIDTH-1:0] operand_c,
    output logic             err_c
);

    localparam int unsigned EXT_W = WIDTH - IMM_W;

    logic [WIDTH-1:0] ext;

    // Sign bit only propagates when sign extension is requested.
    always_comb begin
        ext = {{EXT_W{imm_sign & imm[IMM_W-1]}}, imm};
    end

    always_comb begin
        operand_c = '0;
        err_c     = 1'b0;
        case (sel)
            SRC_B_REG:     operand_c = reg_b;
            SRC_B_INC:     operand_c = WIDTH'(CONST_INC);
            SRC_B_IMM:     operand_c = ext;
            SRC_B_IMM_SH2: operand_c = ext << 2;
`ifdef ALU_SRC_B_LUI_EN
            SRC_B_LUI:     operand_c = {imm, {EXT_W{1'b0}}};
`endif
            default:       err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_src_b_stage.sv
// ALU B-operand stage: forms the operand and delivers it through a 2-entry skid FIFO.
// Optional lui operand (sel=4) is enabled by ALU_SRC_B_LUI_EN.
module alu_src_b_stage
    import alu_src_b_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMM_W     = 16,
    parameter int unsigned CONST_INC = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [IMM_W-1:0] imm,
    input  logic             imm_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             sel_err
);

    typedef struct packed {
        logic [WIDTH-1:0] operand;
        logic             err;
    } entry_t;

    fifo_state_e state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [2];
    entry_t      mem_d [2];
    entry_t      new_entry;
    entry_t      head_d;

    logic             accept;
    logic             emit;
    logic             in_ready_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] data_out_d;
    logic             sel_err_d;
    logic [WIDTH-1:0] form_operand;
    logic             form_err;

    alu_src_b_form #(
        .WIDTH     (WIDTH),
        .IMM_W     (IMM_W),
        .CONST_INC (CONST_INC)
    ) u_form (
        .sel       (sel),
        .reg_b     (reg_b),
        .imm       (imm),
        .imm_sign  (imm_sign),
        .operand_c (form_operand),
        .err_c     (form_err)
    );

    // Next-state and next-output logic; outputs are registered from the next head.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        new_entry  = '{operand: form_operand, err: form_err};
        accept     = in_valid && in_ready;
        emit       = out_valid && out_ready;

        if (flush) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (emit) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !emit)      state_d = ST_FULL;
                    else if (!accept && emit) state_d = ST_EMPTY;
                end
                ST_FULL:  if (emit) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end

        head_d      = mem_d[rd_ptr_d];
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        data_out_d  = out_valid_d ? head_d.operand : '0;
        sel_err_d   = out_valid_d ? head_d.err : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            sel_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            data_out  <= data_out_d;
            sel_err   <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed self-checking bench for alu_src_b_stage (default 32/16/4 parameters).
module tb_alu_src_b_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] reg_b;
    logic [15:0] imm;
    logic        imm_sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_src_b_stage #(
        .WIDTH     (32),
        .IMM_W     (16),
        .CONST_INC (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .reg_b     (reg_b),
        .imm       (imm),
        .imm_sign  (imm_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single clock; returns at the following negedge.
    task automatic send(input logic [2:0] s, input logic [31:0] rb,
                        input logic [15:0] im, input logic isg);
        sel      = s;
        reg_b    = rb;
        imm      = im;
        imm_sign = isg;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sel       = 3'd0;
        reg_b     = 32'h0;
        imm       = 16'h0;
        imm_sign  = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_data_out",  data_out,       32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single transfers
        send(3'd0, 32'h1234_5678, 16'h0, 1'b0);
        chk("reg_valid", 32'(out_valid), 32'd1);
        chk("reg_data",  data_out, 32'h1234_5678);
        send(3'd1, 32'h0, 16'h0, 1'b0);
        chk("inc_data", data_out, 32'h0000_0004);
        chk("inc_err",  32'(sel_err), 32'd0);

        // Extension
        send(3'd2, 32'h0, 16'h8001, 1'b1);
        chk("sext_data", data_out, 32'hFFFF_8001);
        send(3'd2, 32'h0, 16'h8001, 1'b0);
        chk("zext_data", data_out, 32'h0000_8001);
        send(3'd3, 32'h0, 16'h8001, 1'b1);
        chk("sh2_data", data_out, 32'hFFFE_0004);
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_data",  data_out, 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        send(3'd0, 32'hAAAA_0001, 16'h0, 1'b0);
        chk("bp_a_data",  data_out, 32'hAAAA_0001);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        send(3'd0, 32'hBBBB_0002, 16'h0, 1'b0);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_data",  data_out, 32'hAAAA_0001);
        @(negedge clk);
        chk("bp_hold2_data", data_out, 32'hAAAA_0001);
        chk("bp_hold2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_data",  data_out, 32'hBBBB_0002);
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);

        // Simultaneous accept and emit while holding one entry
        sel      = 3'd0;
        reg_b    = 32'hC000_0000;
        in_valid = 1'b1;
        @(negedge clk);
        chk("stream_first", data_out, 32'hC000_0000);
        for (int i = 1; i <= 10; i++) begin
            reg_b = 32'hC000_0000 + 32'(i);
            @(negedge clk);
            chk("stream_data",  data_out, 32'hC000_0000 + 32'(i));
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_end_valid", 32'(out_valid), 32'd0);

        // Illegal and lui selects
        send(3'd4, 32'h0, 16'h1234, 1'b0);
`ifdef ALU_SRC_B_LUI_EN
        chk("lui_data", data_out, 32'h1234_0000);
        chk("lui_err",  32'(sel_err), 32'd0);
`else
        chk("lui_data", data_out, 32'd0);
        chk("lui_err",  32'(sel_err), 32'd1);
`endif
        send(3'd7, 32'hFFFF_FFFF, 16'h1234, 1'b1);
        chk("sel7_data", data_out, 32'd0);
        chk("sel7_err",  32'(sel_err), 32'd1);
        @(negedge clk);
        chk("sel7_clear_err", 32'(sel_err), 32'd0);

        // Flush while full; same-cycle accept is discarded
        out_ready = 1'b0;
        send(3'd0, 32'h1111_1111, 16'h0, 1'b0);
        send(3'd0, 32'h2222_2222, 16'h0, 1'b0);
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        reg_b    = 32'h3333_3333;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready),  32'd1);
        chk("fl_data",  data_out, 32'd0);
        @(negedge clk);
        chk("fl_discard_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stall
        send(3'd7, 32'h0, 16'h0, 1'b0);
        send(3'd0, 32'h4444_4444, 16'h0, 1'b0);
        chk("ar_pre_err", 32'(sel_err), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready),  32'd0);
        chk("ar_data",  data_out, 32'd0);
        chk("ar_err",   32'(sel_err), 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ar_rel_ready", 32'(in_ready), 32'd1);
        chk("ar_rel_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
